// File: rtl/mc_ctrl.sv
// Multi-cycle MIPS controller: sequences fetch/decode/execute/memory/write-back and
// drives every datapath write enable and mux select from the current state and IR fields.
module mc_ctrl #(
   parameter int unsigned MEM_WAIT = 0
) (
   input  logic       clk,
   input  logic       reset,
   input  logic [5:0] op,
   input  logic [5:0] funct,
   input  logic       zero,
   output logic       pc_wr,
   output logic [1:0] pc_src,
   output logic       ir_wr,
   output logic       mem_wr,
   output logic       reg_wr,
   output logic [1:0] reg_dst,
   output logic [1:0] wd_src,
   output logic [1:0] alu_srcb,
   output logic [1:0] alu_op,
   output logic [1:0] e_op,
   output logic [2:0] state,
   output logic       illegal
);

   typedef enum logic [2:0] {
      FETCH  = 3'd0,
      DECODE = 3'd1,
      EXE    = 3'd2,
      MEM    = 3'd3,
      WB     = 3'd4
   } state_t;

   localparam logic [2:0] WaitLast = 3'(MEM_WAIT);

   state_t     state_q, state_d;
   logic [2:0] cnt_q, cnt_d;
   logic       illegal_q, illegal_d;

   logic isR, isAddu, isSubu, isOri, isLw, isSw, isBeq, isLui, isJ, isJal, isSupported;

   assign isR         = (op == 6'h00);
   assign isAddu      = isR && (funct == 6'h21);
   assign isSubu      = isR && (funct == 6'h23);
   assign isOri       = (op == 6'h0D);
   assign isLw        = (op == 6'h23);
   assign isSw        = (op == 6'h2B);
   assign isBeq       = (op == 6'h04);
   assign isLui       = (op == 6'h0F);
   assign isJ         = (op == 6'h02);
   assign isJal       = (op == 6'h03);
   assign isSupported = isAddu | isSubu | isOri | isLw | isSw | isBeq | isLui | isJ | isJal;

   always_ff @(posedge clk) begin
      if (reset) begin
         state_q   <= FETCH;
         cnt_q     <= 3'd0;
         illegal_q <= 1'b0;
      end else begin
         state_q   <= state_d;
         cnt_q     <= cnt_d;
         illegal_q <= illegal_d;
      end
   end

   always_comb begin
      state_d   = state_q;
      cnt_d     = cnt_q;
      illegal_d = illegal_q;
      pc_wr     = 1'b0;
      pc_src    = 2'b00;
      ir_wr     = 1'b0;
      mem_wr    = 1'b0;
      reg_wr    = 1'b0;
      reg_dst   = 2'b00;
      wd_src    = 2'b00;
      alu_srcb  = 2'b00;
      alu_op    = 2'b00;
      e_op      = 2'b00;

      // The extender mode follows the IR everywhere except FETCH, where the IR is stale.
      if (state_q != FETCH) begin
         if (isOri)      e_op = 2'b01;
         else if (isLui) e_op = 2'b10;
         else if (isBeq) e_op = 2'b11;
      end

      case (state_q)
         FETCH: begin
            ir_wr   = 1'b1;
            pc_wr   = 1'b1;
            state_d = DECODE;
         end
         DECODE: begin
            if (isJ || isJal) begin
               pc_wr   = 1'b1;
               pc_src  = 2'b10;
               state_d = FETCH;
               if (isJal) begin
                  reg_wr  = 1'b1;
                  reg_dst = 2'b10;
                  wd_src  = 2'b10;
               end
            end else if (!isSupported) begin
               illegal_d = 1'b1;
               state_d   = FETCH;
            end else begin
               state_d = EXE;
            end
         end
         EXE: begin
            state_d = FETCH;
            if (isAddu || isSubu) begin
               alu_op  = isSubu ? 2'b01 : 2'b00;
               state_d = WB;
            end else if (isOri || isLui) begin
               alu_srcb = 2'b10;
               alu_op   = isLui ? 2'b11 : 2'b10;
               state_d  = WB;
            end else if (isLw || isSw) begin
               alu_srcb = 2'b10;
               cnt_d    = 3'd0;
               state_d  = MEM;
            end else if (isBeq) begin
               alu_op = 2'b01;
               pc_src = 2'b01;
               pc_wr  = zero;
            end
         end
         MEM: begin
            // Store strobes only on the last wait cycle so memory sees a single write.
            if (cnt_q == WaitLast) begin
               mem_wr  = isSw;
               state_d = isLw ? WB : FETCH;
            end else begin
               cnt_d = cnt_q + 3'd1;
            end
         end
         WB: begin
            reg_wr  = 1'b1;
            reg_dst = isR ? 2'b01 : 2'b00;
            wd_src  = isLw ? 2'b01 : 2'b00;
            state_d = FETCH;
         end
         default: begin
            state_d = FETCH;
         end
      endcase

      // Reset must abort any instruction in flight without a partial write.
      if (reset) begin
         pc_wr    = 1'b0;
         pc_src   = 2'b00;
         ir_wr    = 1'b0;
         mem_wr   = 1'b0;
         reg_wr   = 1'b0;
         reg_dst  = 2'b00;
         wd_src   = 2'b00;
         alu_srcb = 2'b00;
         alu_op   = 2'b00;
         e_op     = 2'b00;
      end
   end

   assign state   = state_q;
   assign illegal = illegal_q;

endmodule
